// File: rtl/alu_seq_if.sv
// Request, result and ALU-drive signals of the execute-stage sequencer.
// The sequencer uses the slave modport. Its client and the ALU use the master modport.
interface alu_seq_if #(
    parameter int OP_WIDTH = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [OP_WIDTH-1:0] in_op;
    logic [31:0]         in_a;
    logic [31:0]         in_b;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_result;
    logic                out_err;
    logic [OP_WIDTH-1:0] alu_aluop;
    logic [31:0]         alu_mux1;
    logic [31:0]         alu_mux2;
    logic [31:0]         alu_aluout;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready, alu_aluout,
        input  in_ready, out_valid, out_result, out_err,
               alu_aluop, alu_mux1, alu_mux2
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready, alu_aluout,
        output in_ready, out_valid, out_result, out_err,
               alu_aluop, alu_mux1, alu_mux2
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle sequencer in front of the 32-bit ALU. It runs the ALU ops directly.
// It builds shifts one bit per cycle, because the ALU has no shifter.
module alu_seq #(
    parameter int OP_WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_OR    = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_XOR   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_SLL   = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SRL   = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SRA   = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_SLT   = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_SLTU  = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_FIRST_ILLEGAL = OP_WIDTH'(10);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_reg,  state_next;
    logic [OP_WIDTH-1:0] op_reg,     op_next;
    logic [31:0]         a_reg,      a_next;
    logic [31:0]         b_reg,      b_next;
    logic [4:0]          cnt_reg,    cnt_next;
    logic [31:0]         w_reg,      w_next;
    logic [31:0]         result_reg, result_next;
    logic                err_reg,    err_next;

    logic                in_ready_c;
    logic                out_valid_c;
    logic [OP_WIDTH-1:0] alu_op_c;
    logic [31:0]         alu_mux1_c;
    logic [31:0]         alu_mux2_c;

    logic                in_is_shift;
    logic                slt_bit;
    logic                sltu_bit;
    logic [31:0]         w_shr;

    // One-bit right shift of the working register. Only SRA copies the sign bit into bit 31.
    generate
        for (genvar gi = 0; gi < 31; gi++) begin : g_shr
            assign w_shr[gi] = w_reg[gi+1];
        end
    endgenerate
    assign w_shr[31] = (op_reg == OP_SRA) ? w_reg[31] : 1'b0;

    assign in_is_shift = (bus.in_op == OP_SLL) || (bus.in_op == OP_SRL) ||
                         (bus.in_op == OP_SRA);

    // When the operand signs differ, the sign of a - b can overflow.
    // In that case the operand signs decide the compare.
    assign slt_bit  = (a_reg[31] ^ b_reg[31]) ? a_reg[31] : bus.alu_aluout[31];
    assign sltu_bit = (a_reg[31] ^ b_reg[31]) ? b_reg[31] : bus.alu_aluout[31];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            cnt_reg    <= '0;
            w_reg      <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            cnt_reg    <= cnt_next;
            w_reg      <= w_next;
            result_reg <= result_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        cnt_next    = cnt_reg;
        w_next      = w_reg;
        result_next = result_reg;
        err_next    = err_reg;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        alu_op_c    = OP_ADD;
        alu_mux1_c  = '0;
        alu_mux2_c  = '0;

        case (state_reg)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    op_next    = bus.in_op;
                    a_next     = bus.in_a;
                    b_next     = bus.in_b;
                    cnt_next   = bus.in_b[4:0];
                    w_next     = bus.in_a;
                    err_next   = (bus.in_op >= OP_FIRST_ILLEGAL);
                    state_next = in_is_shift ? SHIFT : EXEC;
                end
            end

            EXEC: begin
                state_next = DONE;
                case (op_reg)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        alu_op_c    = op_reg;
                        alu_mux1_c  = a_reg;
                        alu_mux2_c  = b_reg;
                        result_next = bus.alu_aluout;
                    end
                    OP_SLT: begin
                        alu_op_c    = OP_SUB;
                        alu_mux1_c  = a_reg;
                        alu_mux2_c  = b_reg;
                        result_next = {31'b0, slt_bit};
                    end
                    OP_SLTU: begin
                        alu_op_c    = OP_SUB;
                        alu_mux1_c  = a_reg;
                        alu_mux2_c  = b_reg;
                        result_next = {31'b0, sltu_bit};
                    end
                    default: begin
                        // An illegal opcode leaves the ALU idle at 0 + 0. Its result is zero.
                        result_next = '0;
                    end
                endcase
            end

            SHIFT: begin
                if (cnt_reg != 5'd0) begin
                    cnt_next = cnt_reg - 5'd1;
                    if (op_reg == OP_SLL) begin
                        // Shift left by one is w + w through the ALU adder.
                        alu_op_c   = OP_ADD;
                        alu_mux1_c = w_reg;
                        alu_mux2_c = w_reg;
                        w_next     = bus.alu_aluout;
                    end else begin
                        w_next = w_shr;
                    end
                end else begin
                    result_next = w_reg;
                    state_next  = DONE;
                end
            end

            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_result = result_reg;
    assign bus.out_err    = err_reg;
    assign bus.alu_aluop  = alu_op_c;
    assign bus.alu_mux1   = alu_mux1_c;
    assign bus.alu_mux2   = alu_mux2_c;
endmodule

// File: tb/tb_alu_seq.sv
// Directed vector bench for alu_seq. A small behavioural ALU model answers the sequencer's ALU drive.
// Every expected result and latency is a hand-computed constant.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_seq_if #(.OP_WIDTH(4)) bus ();

    alu_seq #(.OP_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural model of the external ALU, combinational in the same cycle.
    always_comb begin
        case (bus.alu_aluop)
            4'd0:    bus.alu_aluout = bus.alu_mux1 + bus.alu_mux2;
            4'd1:    bus.alu_aluout = bus.alu_mux1 - bus.alu_mux2;
            4'd2:    bus.alu_aluout = bus.alu_mux1 & bus.alu_mux2;
            4'd3:    bus.alu_aluout = bus.alu_mux1 | bus.alu_mux2;
            4'd4:    bus.alu_aluout = bus.alu_mux1 ^ bus.alu_mux2;
            default: bus.alu_aluout = 32'h0;
        endcase
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        err;
        int          lat;
        int          alu_act;   // expected cycles with ALU driven w+w (nonzero), -1 = don't check
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a request at a negedge and return once the accept edge has passed.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int t;
        @(negedge clk);
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("issue_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        // Scramble the inputs so that a late capture would show up.
        bus.in_op    = 4'd3;
        bus.in_a     = 32'hDEAD_BEEF;
        bus.in_b     = 32'h0000_001F;
    endtask

    // Count edges from the accept edge (the accept edge is edge 1) until out_valid is seen.
    task automatic wait_result(output int lat, output int act);
        lat = 1;
        act = 0;
        while (!bus.out_valid && lat < 60) begin
            if (bus.alu_aluop == 4'd0 && bus.alu_mux1 != 32'd0 && bus.alu_mux1 == bus.alu_mux2)
                act++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) check("result_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        int act;
        logic [31:0] held;

        vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 2,  -1};
        vecs[1]  = '{4'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 2,  -1};
        vecs[2]  = '{4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 2,  -1};
        vecs[3]  = '{4'd3,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 2,  -1};
        vecs[4]  = '{4'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 2,  -1};
        vecs[5]  = '{4'd8,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 2,  -1};
        vecs[6]  = '{4'd9,  32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 2,  -1};
        vecs[7]  = '{4'd8,  32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 2,  -1};
        vecs[8]  = '{4'd8,  32'h0000_0003, 32'h0000_0005, 32'h0000_0001, 1'b0, 2,  -1};
        vecs[9]  = '{4'd9,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2,  -1};
        vecs[10] = '{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 2,  -1};
        vecs[11] = '{4'd7,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 6,  -1};
        vecs[12] = '{4'd5,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 33, 31};
        vecs[13] = '{4'd6,  32'h0000_ABCD, 32'hFFFF_FFE0, 32'h0000_ABCD, 1'b0, 2,  -1};
        vecs[14] = '{4'd6,  32'h8000_0000, 32'h0000_0003, 32'h1000_0000, 1'b0, 5,  -1};
        vecs[15] = '{4'd12, 32'h0000_1234, 32'h0000_0001, 32'h0000_0000, 1'b1, 2,  -1};
        vecs[16] = '{4'd0,  32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 2,  -1};
        vecs[17] = '{4'd5,  32'h0000_0003, 32'h0000_0002, 32'h0000_000C, 1'b0, 4,  2};

        bus.in_valid  = 1'b0;
        bus.in_op     = 4'd0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",   {31'd0, bus.in_ready},  32'd1);
        check("rst_out_valid",  {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_result", bus.out_result,         32'd0);
        check("rst_out_err",    {31'd0, bus.out_err},   32'd0);
        check("rst_alu_aluop",  {28'd0, bus.alu_aluop}, 32'd0);
        check("rst_alu_mux1",   bus.alu_mux1,           32'd0);
        check("rst_alu_mux2",   bus.alu_mux2,           32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_result(lat, act);
            $display("txn %0d: op=%0d a=%08h b=%08h -> result=%08h err=%0b latency=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, bus.out_result, bus.out_err, lat);
            check($sformatf("v%0d_result", i),  bus.out_result,         vecs[i].res);
            check($sformatf("v%0d_err", i),     {31'd0, bus.out_err},   {31'd0, vecs[i].err});
            check($sformatf("v%0d_latency", i), lat,                    vecs[i].lat);
            if (vecs[i].alu_act >= 0)
                check($sformatf("v%0d_alu_ww_cycles", i), act, vecs[i].alu_act);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid_drop", i), {31'd0, bus.out_valid}, 32'd0);
        end

        // Backpressure in DONE. A second request is held until after the handshake.
        bus.out_ready = 1'b0;
        issue(4'd0, 32'd10, 32'd20);
        wait_result(lat, act);
        $display("txn bp1: ADD 10+20 -> result=%08h latency=%0d", bus.out_result, lat);
        check("bp_latency", lat, 2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_op    = 4'd0;
            bus.in_a     = 32'd100;
            bus.in_b     = 32'd1;
            check($sformatf("bp_hold%0d_valid", c),    {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("bp_hold%0d_result", c),   bus.out_result,         32'd30);
            check($sformatf("bp_hold%0d_in_ready", c), {31'd0, bus.in_ready},  32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_after_hs_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("bp_after_hs_out_valid", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_second_accepted", {31'd0, bus.in_ready}, 32'd0);
        wait_result(lat, act);
        $display("txn bp2: ADD 100+1 -> result=%08h latency=%0d", bus.out_result, lat);
        check("bp_second_result",  bus.out_result, 32'd101);
        check("bp_second_latency", lat,            2);
        @(posedge clk);
        #1;

        // Reset in the middle of a shift, when cnt has counted down from 20 to 10.
        issue(4'd6, 32'hFFFF_0000, 32'd20);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        $display("txn rst_mid_shift: in_ready=%0b out_valid=%0b result=%08h",
                 bus.in_ready, bus.out_valid, bus.out_result);
        check("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_result",    bus.out_result,         32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(4'd0, 32'd2, 32'd3);
        wait_result(lat, act);
        $display("txn post_rst: ADD 2+3 -> result=%08h latency=%0d", bus.out_result, lat);
        check("postrst_result",  bus.out_result, 32'd5);
        check("postrst_latency", lat,            2);
        held = bus.out_result;
        @(posedge clk);
        #1;
        check("postrst_done_exit", {31'd0, bus.out_valid}, 32'd0);
        check("postrst_result_kept", bus.out_result, held);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle sequencer that fronts the 32-bit `alu` in the execute stage. It accepts one operation per valid/ready handshake and drives the ALU's `aluop` and operand inputs. Shifts are performed iteratively, one bit position per cycle, because the ALU has no shifter. The result is held until the downstream consumer accepts it.

## Interface
- `OP_WIDTH`, 4, width of the opcode field; matches `alu`.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  sequencer can accept a request.
- `in_op`  in  OP_WIDTH  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU; 10–15 illegal.
- `in_a`, `in_b`  in  32  operands; shifts use `in_b[4:0]` as shamt.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `out_result`  out  32  result.
- `out_err`  out  1  the request carried an illegal opcode.
- `alu_aluop`  out  OP_WIDTH  drives `alu.aluop`.
- `alu_mux1`, `alu_mux2`  out  32  drive `alu.alumux1_out` and `alu.alumux2_out`.
- `alu_aluout`  in  32  from `alu.aluout`; combinational, same cycle.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - EXEC: one cycle.
  - SHIFT: shamt+1 cycles.
  - DONE: `out_valid`=1.
- Accept edge = rising edge with `in_valid`&`in_ready`. It latches op, a, b, shamt=`in_b[4:0]` and err=(op≥10).
- IDLE → EXEC on accept for ops 0–4, 8, 9 and illegal ops. IDLE → SHIFT on accept for ops 5–7.
- EXEC drives the ALU and latches the result at the next edge, then goes to DONE.
  - ADD/SUB/AND/OR/XOR: `alu_aluop`=op, mux1=a, mux2=b, result=`alu_aluout`.
  - SLT/SLTU: `alu_aluop`=1 (SUB).
    - SLT result = {31'b0, (a[31]^b[31]) ? a[31] : `alu_aluout`[31]}.
    - SLTU result = {31'b0, borrow}, where borrow = (a<b unsigned) = (a[31]^b[31]) ? b[31] : `alu_aluout`[31].
  - Illegal: result=0, err=1, ALU driven as ADD 0+0.
- SHIFT has a working register w (loaded with a) and a counter cnt (loaded with shamt).
  - Each cycle with cnt≠0, w is updated:
    - SLL: w ← `alu_aluout` with `alu_aluop`=0, mux1=mux2=w (w+w).
    - SRL: w ← {1'b0, w[31:1]}.
    - SRA: w ← {w[31], w[31:1]}.
  - cnt decrements on each such cycle.
  - With cnt=0: result ← w, go to DONE.
- In IDLE, DONE and non-SLL SHIFT cycles the ALU is driven `alu_aluop`=0, mux1=mux2=0.
- DONE holds `out_result`/`out_err` stable until `out_valid`&`out_ready`, then goes to IDLE. `in_ready` stays 0 in DONE, so there is no same-cycle re-accept.
- `in_*` changes while not in IDLE are ignored.

## Timing
- Reset: state=IDLE, `in_ready`=1, `out_valid`=0, `out_result`=0, `out_err`=0, cnt=0, `alu_aluop`=0, `alu_mux1`=`alu_mux2`=0.
- Reset mid-operation abandons the op, with no output. The first accept can occur on the first edge with `rst` low.
- Latency: `out_valid` rises on the 2nd edge after the accept edge for EXEC ops, and on the (shamt+2)th edge for shifts. shamt=0 gives 2 and result=a. shamt=31 gives 33.
- Minimum issue interval: 3 cycles (EXEC op consumed immediately).
- `out_ready` held high before DONE is harmless. DONE lasts ≥1 cycle.
- `in_ready` is a registered-state decode only; it has no combinational path from `in_valid`. `out_valid` depends only on state.
- Shift amounts use only `in_b[4:0]`. `in_b[31:5]` are ignored.

## Test plan
- ADD 0xFFFFFFFF+0x00000001 → `out_result`=0x00000000, `out_valid` 2 edges after accept. SUB 5−7 → 0xFFFFFFFE.
- SLT 0x80000000 vs 0x00000001 → 1. SLTU same operands → 0. SLT 0x7FFFFFFF vs 0x80000000 (subtraction overflow) → 0.
- SRA 0x80000000 by `in_b`=0x00000024 (shamt 4) → 0xF8000000 after 6 edges. SLL 0x00000001 by 31 → 0x80000000 after 33 edges, with ALU seen driven ADD w+w. SRL by 0 → a after 2 edges.
- Backpressure: `out_ready` low for 5 cycles in DONE → result and `out_valid` stable, `in_ready`=0, second `in_valid` not accepted until the cycle after the handshake.
- Illegal op 12 with a=0x1234 → `out_result`=0, `out_err`=1. The next legal op clears `out_err`.
- `rst` asserted during SHIFT cnt=10 → next cycle IDLE, `out_valid`=0, `in_ready`=1. A following ADD 2+3 → 5 with normal latency.
